// File: rtl/qam_upconverter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qam_upconverter_pkg
//  Description : Shared widths, LUT geometry and the quarter-wave sine
//                generator for the QAM upconverter.
//  Revision    : 1.0 - initial release
// ============================================================================
package qam_upconverter_pkg;

  localparam int PHASE_W     = 24;
  localparam int OUT_W       = 16;
  localparam int IN_W        = 35;
  localparam int LUT_ADDR_W  = 10;
  localparam int LUT_DEPTH   = 257;
  localparam int SCALE_SHIFT = 17;

  // Truncated baseband sample width (top bits of the CIC word)
  localparam int SAMP_W  = IN_W - SCALE_SHIFT;
  localparam int SIN_W   = 16;
  localparam int PROD_W  = SAMP_W + SIN_W;
  // Quarter-table index needs one extra bit to reach entry 256
  localparam int IDX_W   = LUT_ADDR_W - 1;
  localparam int QUARTER = 1 << (LUT_ADDR_W - 2);
  localparam int QSIN_AMP = 32767;

  // pi scaled by 2^60
  localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

  // round(32767 * sin(pi*k/512)) evaluated at elaboration time with a
  // 60-bit fixed-point Taylor series; the residual error is far below the
  // rounding step so every entry rounds exactly as the real-valued formula.
  function automatic logic [SIN_W-1:0] quarter_sine(input int k);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] div;
    x    = (128'(k) * 128'(PI_Q60)) >> 9;
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      div  = 128'(2 * n * (2 * n + 1));
      term = -((term * x2) >>> 60) / div;
      sum  = sum + term;
    end
    sum = (sum * 128'(QSIN_AMP) + (128'sd1 <<< 59)) >>> 60;
    return sum[SIN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/qam_upconverter_sin_lut.sv
`default_nettype none
// ============================================================================
//  Module      : qam_sin_lut
//  Description : Registered quarter-wave sine/cosine lookup, one cycle of
//                latency. Cosine is the sine table offset by a quarter turn.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_sin_lut
  import qam_upconverter_pkg::*;
(
  input  logic                    clk,
  input  logic [LUT_ADDR_W-1:0]   addr,
  output logic signed [SIN_W-1:0] sin_out,
  output logic signed [SIN_W-1:0] cos_out
);

  logic [SIN_W-1:0]      table_w [LUT_DEPTH];
  logic [LUT_ADDR_W-1:0] w_cos_addr;
  logic [IDX_W-1:0]      w_sin_idx;
  logic [IDX_W-1:0]      w_cos_idx;

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_table
    localparam logic [SIN_W-1:0] C_ENTRY = quarter_sine(k);
    assign table_w[k] = C_ENTRY;
  end

  assign w_cos_addr = addr + LUT_ADDR_W'(QUARTER);

  // Odd quadrants read the table mirrored about the quarter point
  assign w_sin_idx = addr[LUT_ADDR_W-2]
                   ? IDX_W'(QUARTER) - {1'b0, addr[LUT_ADDR_W-3:0]}
                   : {1'b0, addr[LUT_ADDR_W-3:0]};
  assign w_cos_idx = w_cos_addr[LUT_ADDR_W-2]
                   ? IDX_W'(QUARTER) - {1'b0, w_cos_addr[LUT_ADDR_W-3:0]}
                   : {1'b0, w_cos_addr[LUT_ADDR_W-3:0]};

  // Lower half of the circle negates the folded table value
  always_ff @(posedge clk) begin
    sin_out <= addr[LUT_ADDR_W-1] ? -$signed(table_w[w_sin_idx])
                                  :  $signed(table_w[w_sin_idx]);
    cos_out <= w_cos_addr[LUT_ADDR_W-1] ? -$signed(table_w[w_cos_idx])
                                        :  $signed(table_w[w_cos_idx]);
  end

endmodule
`default_nettype wire

// File: rtl/qam_upconverter.sv
`default_nettype none
// ============================================================================
//  Module      : qam_upconverter
//  Description : Mixes CIC-interpolated I/Q onto an NCO carrier:
//                dac_out = sat(round((I*cos - Q*sin) / 2^17)), 4-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_upconverter
  import qam_upconverter_pkg::*;
#(
  parameter int PHASE_W = qam_upconverter_pkg::PHASE_W,
  parameter int OUT_W   = qam_upconverter_pkg::OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  cic_i_in,
  input  logic signed [IN_W-1:0]  cic_q_in,
  input  logic                    in_valid,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic                    phase_clr,
  output logic signed [OUT_W-1:0] dac_out,
  output logic                    out_valid
);

  localparam int SUM_W = PROD_W + 2;
  localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(64'sd1 <<< (SCALE_SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN    = SUM_W'(-(64'sd1 <<< (OUT_W - 1)));

  logic [PHASE_W-1:0]       r_acc;
  logic [LUT_ADDR_W-1:0]    w_addr;
  logic                     w_unused_lsbs;

  logic signed [SAMP_W-1:0] r_s1_i;
  logic signed [SAMP_W-1:0] r_s1_q;
  logic [LUT_ADDR_W-1:0]    r_s1_addr;
  logic                     r_s1_valid;

  logic signed [SIN_W-1:0]  w_lut_sin;
  logic signed [SIN_W-1:0]  w_lut_cos;
  logic signed [SAMP_W-1:0] r_s2_i;
  logic signed [SAMP_W-1:0] r_s2_q;
  logic                     r_s2_valid;

  logic signed [PROD_W-1:0] w_pi;
  logic signed [PROD_W-1:0] w_pq;
  logic signed [PROD_W-1:0] r_s3_pi;
  logic signed [PROD_W-1:0] r_s3_pq;
  logic                     r_s3_valid;

  logic signed [SUM_W-1:0]  w_diff;
  logic signed [SUM_W-1:0]  w_scaled;
  logic signed [OUT_W-1:0]  w_sat;

  // The CIC fractional bits are dropped by truncation
  assign w_unused_lsbs = ^{cic_i_in[IN_W-SAMP_W-1:0], cic_q_in[IN_W-SAMP_W-1:0]};

  // A phase clear coinciding with a strobe makes that sample use phase 0
  assign w_addr = phase_clr ? '0 : r_acc[PHASE_W-1 -: LUT_ADDR_W];

  // NCO accumulator: advances only on accepted samples, wraps silently
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (phase_clr) begin
      r_acc <= in_valid ? freq_word : '0;
    end else if (in_valid) begin
      r_acc <= r_acc + freq_word;
    end
  end

  // Stage 1: capture truncated I/Q and the LUT address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
    end
    if (in_valid) begin
      r_s1_i    <= cic_i_in[IN_W-1 -: SAMP_W];
      r_s1_q    <= cic_q_in[IN_W-1 -: SAMP_W];
      r_s1_addr <= w_addr;
    end
  end

  qam_sin_lut u_lut (
    .clk     (clk),
    .addr    (r_s1_addr),
    .sin_out (w_lut_sin),
    .cos_out (w_lut_cos)
  );

  // Stage 2: carry I/Q alongside the LUT read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
    end
    r_s2_i <= r_s1_i;
    r_s2_q <= r_s1_q;
  end

  assign w_pi = $signed({{SIN_W{r_s2_i[SAMP_W-1]}}, r_s2_i})
              * $signed({{SAMP_W{w_lut_cos[SIN_W-1]}}, w_lut_cos});
  assign w_pq = $signed({{SIN_W{r_s2_q[SAMP_W-1]}}, r_s2_q})
              * $signed({{SAMP_W{w_lut_sin[SIN_W-1]}}, w_lut_sin});

  // Stage 3: full-precision mixer products
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s3_valid <= 1'b0;
    end else begin
      r_s3_valid <= r_s2_valid;
    end
    r_s3_pi <= w_pi;
    r_s3_pq <= w_pq;
  end

  assign w_diff   = SUM_W'(r_s3_pi) - SUM_W'(r_s3_pq);
  assign w_scaled = (w_diff + ROUND_BIAS) >>> SCALE_SHIFT;

  // Clamp the rescaled difference to the output range
  always_comb begin
    w_sat = w_scaled[OUT_W-1:0];
    if (w_scaled > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_scaled < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  // Stage 4: output register, holds its value between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        dac_out <= w_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qam_upconverter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qam_upconverter
//  Description : Self-checking bench for qam_upconverter against a
//                trigonometric reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_upconverter;

  localparam int PHASE_W = 24;
  localparam int OUT_W   = 16;
  localparam int unsigned MASK = (1 << PHASE_W) - 1;
  localparam real PI = 3.14159265358979323846;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [34:0]             cic_i_in = '0;
  logic [34:0]             cic_q_in = '0;
  logic                    in_valid = 1'b0;
  logic [PHASE_W-1:0]      freq_word = '0;
  logic                    phase_clr = 1'b0;
  logic signed [OUT_W-1:0] dac_out;
  logic                    out_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int unsigned m_acc = 0;
  int exp_val[$];
  int exp_cyc[$];
  int cap_val[$];
  int cap_cyc[$];

  qam_upconverter #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cic_i_in  (cic_i_in),
    .cic_q_in  (cic_q_in),
    .in_valid  (in_valid),
    .freq_word (freq_word),
    .phase_clr (phase_clr),
    .dac_out   (dac_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output strobe with the cycle it appeared in
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      cap_val.push_back(int'(dac_out));
      cap_cyc.push_back(cyc);
    end
  end

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(0.5 - x));
  endfunction

  // Expected passband sample for a baseband pair at a given carrier phase
  function automatic int model_out(input int i18, input int q18, input int unsigned ph);
    real    ang;
    longint c, s, d, y;
    ang = 2.0 * PI * real'(ph >> (PHASE_W - 10)) / 1024.0;
    c = rnd(32767.0 * $cos(ang));
    s = rnd(32767.0 * $sin(ang));
    d = longint'(i18) * c - longint'(q18) * s;
    y = (d + 64'sd65536) >>> 17;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  // One clock of stimulus; also advances the reference model
  task automatic drive(input bit iv, input int i18, input int q18,
                       input int unsigned fw, input bit pc, input bit rst);
    int unsigned ph;
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = iv;
    phase_clr = pc;
    freq_word = PHASE_W'(fw);
    cic_i_in  = {18'(i18), 17'($urandom)};
    cic_q_in  = {18'(q18), 17'($urandom)};
    if (rst) begin
      m_acc = 0;
      while (exp_cyc.size() > 0 && exp_cyc[$] > cyc) begin
        void'(exp_cyc.pop_back());
        void'(exp_val.pop_back());
      end
    end else begin
      if (iv) begin
        ph = pc ? 0 : m_acc;
        exp_val.push_back(model_out(i18, q18, ph));
        exp_cyc.push_back(cyc + 4);
      end
      if (pc) m_acc = iv ? (fw & MASK) : 0;
      else if (iv) m_acc = (m_acc + fw) & MASK;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    exp_val.delete(); exp_cyc.delete(); cap_val.delete(); cap_cyc.delete();
  endtask

  function automatic int rand18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 65536, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (dac_out !== 16'sd0) begin
      errors++; $display("FAIL reset_dac_out: got %0d expected 0", dac_out);
    end
    cap_val.delete(); cap_cyc.delete();
    idle(8);
    checks++;
    if (cap_val.size() != 0) begin
      errors++; $display("FAIL reset_ignored_strobe: got %0d outputs expected 0", cap_val.size());
    end
  endtask

  task automatic test_dc();
    int s;
    do_reset();
    drive(1'b1, 65536, 0, 0, 1'b0, 1'b0);
    s = cyc;
    idle(8);
    checks++;
    if (cap_val.size() != 1) begin
      errors++; $display("FAIL dc_count: got %0d outputs expected 1", cap_val.size());
    end else begin
      checks++;
      if (cap_val[0] != 16384) begin
        errors++; $display("FAIL dc_value: got %0d expected 16384", cap_val[0]);
      end
      checks++;
      if (cap_cyc[0] != s + 4) begin
        errors++; $display("FAIL dc_latency: got %0d cycles expected 4", cap_cyc[0] - s);
      end
    end
  endtask

  task automatic test_rotation();
    int rot_exp [4];
    int s;
    rot_exp = '{16384, 0, -16383, 0};
    do_reset();
    s = cyc + 1;
    for (int k = 0; k < 4; k++) drive(1'b1, 65536, 0, 1 << 22, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (cap_val.size() != 4) begin
      errors++; $display("FAIL rot_count: got %0d outputs expected 4", cap_val.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap_val[k] != rot_exp[k] || cap_cyc[k] != s + 4 + k) begin
          errors++;
          $display("FAIL rot_sample %0d: got %0d@%0d expected %0d@%0d",
                   k, cap_val[k], cap_cyc[k], rot_exp[k], s + 4 + k);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 2; k++) drive(1'b1, 131071, -131072, 1 << 21, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (cap_val.size() != 2) begin
      errors++; $display("FAIL sat_pos_count: got %0d outputs expected 2", cap_val.size());
    end else begin
      checks++;
      if (cap_val[1] != 32767) begin
        errors++; $display("FAIL sat_pos: got %0d expected 32767", cap_val[1]);
      end
      checks++;
      if (cap_val[0] != exp_val[0]) begin
        errors++; $display("FAIL sat_pos_first: got %0d expected %0d", cap_val[0], exp_val[0]);
      end
    end
    do_reset();
    for (int k = 0; k < 2; k++) drive(1'b1, -131072, 131071, 1 << 21, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (cap_val.size() != 2) begin
      errors++; $display("FAIL sat_neg_count: got %0d outputs expected 2", cap_val.size());
    end else begin
      checks++;
      if (cap_val[1] != -32768) begin
        errors++; $display("FAIL sat_neg: got %0d expected -32768", cap_val[1]);
      end
    end
  endtask

  task automatic test_phase_clr();
    int clr_exp [5];
    clr_exp = '{16384, 0, -16383, 16384, 0};
    do_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 65536, 0, 1 << 22, 1'b0, 1'b0);
    drive(1'b1, 65536, 0, 1 << 22, 1'b1, 1'b0);
    drive(1'b1, 65536, 0, 1 << 22, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (cap_val.size() != 5) begin
      errors++; $display("FAIL clr_count: got %0d outputs expected 5", cap_val.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (cap_val[k] != clr_exp[k]) begin
          errors++; $display("FAIL clr_sample %0d: got %0d expected %0d", k, cap_val[k], clr_exp[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 80; k++) begin
      drive($urandom_range(0, 3) != 0, rand18(), rand18(),
            $urandom_range(0, MASK), $urandom_range(0, 9) == 0, 1'b0);
    end
    idle(8);
    checks++;
    if (cap_val.size() != exp_val.size()) begin
      errors++; $display("FAIL b2b_count: got %0d outputs expected %0d", cap_val.size(), exp_val.size());
    end
    for (int n = 0; n < cap_val.size() && n < exp_val.size(); n++) begin
      checks++;
      if (cap_val[n] !== exp_val[n] || cap_cyc[n] !== exp_cyc[n]) begin
        errors++;
        $display("FAIL b2b_sample %0d: got %0d@%0d expected %0d@%0d",
                 n, cap_val[n], cap_cyc[n], exp_val[n], exp_cyc[n]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 1024; k++) drive(1'b1, rand18(), rand18(), MASK, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (cap_val.size() != 1024) begin
      errors++; $display("FAIL wrap_count: got %0d outputs expected 1024", cap_val.size());
    end
    for (int n = 0; n < cap_val.size() && n < exp_val.size(); n++) begin
      checks++;
      if (cap_val[n] !== exp_val[n] || cap_cyc[n] !== exp_cyc[n]) begin
        errors++;
        $display("FAIL wrap_sample %0d: got %0d@%0d expected %0d@%0d",
                 n, cap_val[n], cap_cyc[n], exp_val[n], exp_cyc[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc;
    int early;
    rc = 0;
    do_reset();
    idle(1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, rand18(), rand18(), 1 << 22, 1'b0, k == 5);
      if (k == 5) rc = cyc;
      if (k == 6) begin
        @(negedge clk);
        checks++;
        if (dac_out !== 16'sd0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL midreset_clear: got dac_out=%0d out_valid=%b expected 0/0", dac_out, out_valid);
        end
      end
    end
    idle(8);
    early = 0;
    foreach (cap_cyc[n]) if (cap_cyc[n] <= rc) early++;
    checks++;
    if (early != 1) begin
      errors++; $display("FAIL midreset_pre_count: got %0d outputs expected 1", early);
    end
    checks++;
    if (cap_val.size() != exp_val.size()) begin
      errors++; $display("FAIL midreset_count: got %0d outputs expected %0d", cap_val.size(), exp_val.size());
    end
    for (int n = 0; n < cap_val.size() && n < exp_val.size(); n++) begin
      checks++;
      if (cap_val[n] !== exp_val[n] || cap_cyc[n] !== exp_cyc[n]) begin
        errors++;
        $display("FAIL midreset_sample %0d: got %0d@%0d expected %0d@%0d",
                 n, cap_val[n], cap_cyc[n], exp_val[n], exp_cyc[n]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 65536, 0, 0, 1'b0, 1'b0);
    idle(6);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, rand18(), rand18(), 0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (int'(dac_out) != 16384 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_value: got %0d valid=%b expected 16384 valid=0", dac_out, out_valid);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dc();
    test_rotation();
    test_saturation();
    test_phase_clr();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
